// File: rtl/aead_serial_ctrl.sv
// Serial front-end and sequencer for the ASCON AEAD core: gathers key/nonce/AD/text (and tag
// when decrypting) as W-bit beats, launches the core, verifies the tag and streams results out.
module aead_serial_ctrl #(
  parameter int unsigned K = 128,
  parameter int unsigned L = 40,
  parameter int unsigned Y = 40,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           mode_i,
  output logic           busy_o,
  input  logic [W-1:0]   in_data_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  output logic [W-1:0]   out_data_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic           out_last_o,
  output logic           done_o,
  output logic           auth_fail_o,
  output logic [K-1:0]   core_key_o,
  output logic [127:0]   core_nonce_o,
  output logic [L-1:0]   core_ad_o,
  output logic [Y-1:0]   core_text_in_o,
  output logic           core_mode_o,
  output logic           core_start_o,
  input  logic [Y-1:0]   core_text_out_i,
  input  logic [127:0]   core_tag_i,
  input  logic           core_done_i
);

  localparam int unsigned KeyBeats   = K / W;
  localparam int unsigned NonceBeats = 128 / W;
  localparam int unsigned AdBeats    = L / W;
  localparam int unsigned TextBeats  = Y / W;
  localparam int unsigned TagBeats   = 128 / W;
  localparam int unsigned MaxBeats   = KeyBeats + NonceBeats + AdBeats + TextBeats + TagBeats;
  localparam int unsigned CW         = $clog2(MaxBeats + 1);
  localparam int unsigned SW         = Y + 128;

  localparam logic [CW-1:0] KeyEnd    = CW'(KeyBeats);
  localparam logic [CW-1:0] NonceEnd  = CW'(KeyBeats + NonceBeats);
  localparam logic [CW-1:0] AdEnd     = CW'(KeyBeats + NonceBeats + AdBeats);
  localparam logic [CW-1:0] TextEnd   = CW'(KeyBeats + NonceBeats + AdBeats + TextBeats);
  localparam logic [CW-1:0] InLastEnc = CW'(MaxBeats - TagBeats - 1);
  localparam logic [CW-1:0] InLastDec = CW'(MaxBeats - 1);
  localparam logic [CW-1:0] OutLastEnc = CW'(TextBeats + TagBeats - 1);
  localparam logic [CW-1:0] OutLastDec = CW'(TextBeats - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StOut, StDone} state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [K-1:0]    key_q, key_d;
  logic [127:0]    nonce_q, nonce_d;
  logic [L-1:0]    ad_q, ad_d;
  logic [Y-1:0]    text_q, text_d;
  logic [127:0]    tag_q, tag_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic            auth_fail_q, auth_fail_d;

  logic in_last, out_last;

  // One beat counter serves both the load phase and the output phase.
  assign in_last  = (cnt_q == (mode_q ? InLastDec : InLastEnc));
  assign out_last = (cnt_q == (mode_q ? OutLastDec : OutLastEnc));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      key_q       <= '0;
      nonce_q     <= '0;
      ad_q        <= '0;
      text_q      <= '0;
      tag_q       <= '0;
      sr_q        <= '0;
      auth_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ad_q        <= ad_d;
      text_q      <= text_d;
      tag_q       <= tag_d;
      sr_q        <= sr_d;
      auth_fail_q <= auth_fail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    ad_d        = ad_q;
    text_d      = text_q;
    tag_d       = tag_q;
    sr_d        = sr_q;
    auth_fail_d = auth_fail_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d      = mode_i;
          cnt_d       = '0;
          auth_fail_d = 1'b0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        if (in_valid_i) begin
          // The counter position selects which field the beat shifts into.
          if (cnt_q < KeyEnd) begin
            key_d = K'({key_q, in_data_i});
          end else if (cnt_q < NonceEnd) begin
            nonce_d = 128'({nonce_q, in_data_i});
          end else if (cnt_q < AdEnd) begin
            ad_d = L'({ad_q, in_data_i});
          end else if (cnt_q < TextEnd) begin
            text_d = Y'({text_q, in_data_i});
          end else begin
            tag_d = 128'({tag_q, in_data_i});
          end
          if (in_last) begin
            cnt_d   = '0;
            state_d = StStart;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (core_done_i) begin
          sr_d  = {core_text_out_i, core_tag_i};
          cnt_d = '0;
          if (mode_q && (core_tag_i != tag_q)) begin
            auth_fail_d = 1'b1;
            state_d     = StDone;
          end else begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (out_ready_i) begin
          sr_d  = {sr_q[SW-W-1:0], {W{1'b0}}};
          cnt_d = cnt_q + CW'(1);
          if (out_last) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy_o         = (state_q != StIdle);
  assign in_ready_o     = (state_q == StLoad);
  assign out_valid_o    = (state_q == StOut);
  assign out_data_o     = sr_q[SW-1 -: W];
  assign out_last_o     = (state_q == StOut) && out_last;
  assign done_o         = (state_q == StDone);
  assign auth_fail_o    = auth_fail_q;
  assign core_key_o     = key_q;
  assign core_nonce_o   = nonce_q;
  assign core_ad_o      = ad_q;
  assign core_text_in_o = text_q;
  assign core_mode_o    = mode_q;
  assign core_start_o   = (state_q == StStart);

endmodule

// File: tb/tb_aead_serial_ctrl.sv
// Bench for aead_serial_ctrl: transaction-level model of expected beats, one negedge checker,
// and directed scenarios (encrypt, decrypt match/mismatch, stalls, resets, spurious events).
module tb_aead_serial_ctrl;

  logic         clk, rst;
  logic         start_in, mode_in;
  logic         busy;
  logic [7:0]   in_data;
  logic         in_valid, in_ready;
  logic [7:0]   out_data;
  logic         out_valid, out_ready, out_last;
  logic         done, auth_fail;
  logic [127:0] core_key, core_nonce;
  logic [39:0]  core_ad, core_text_in;
  logic         core_mode, core_start;
  logic [39:0]  core_text_out;
  logic [127:0] core_tag;
  logic         cd_model, spur_cd;
  wire          core_done = cd_model | spur_cd;

  aead_serial_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_in),
    .mode_i         (mode_in),
    .busy_o         (busy),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_last_o     (out_last),
    .done_o         (done),
    .auth_fail_o    (auth_fail),
    .core_key_o     (core_key),
    .core_nonce_o   (core_nonce),
    .core_ad_o      (core_ad),
    .core_text_in_o (core_text_in),
    .core_mode_o    (core_mode),
    .core_start_o   (core_start),
    .core_text_out_i(core_text_out),
    .core_tag_i     (core_tag),
    .core_done_i    (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model (written by the stimulus only).
  logic [7:0] b [58];
  logic [7:0] exp_bytes [21];
  int         exp_n, exp_in;
  logic       exp_mode, exp_auth, exp_done;
  int         txn, pin_req, pin_kind, n_tmo;

  // Checker state (written by the checker only).
  int         nvec, nerr;
  int         txn_seen, pin_seen, ncyc, in_cnt, oidx, done_cnt;
  int         last_in_at, core_done_at, last_out_at;
  logic       started, got_cd, hold_v;
  logic [8:0] hold_dat;
  logic [167:0] got;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Core model: fixed results, done two cycles after launch.
  initial begin
    core_text_out = 40'h0123456789;
    core_tag      = {16{8'hA5}};
    cd_model      = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && core_start) begin
        repeat (2) @(posedge clk);
        #1 cd_model = 1'b1;
        @(posedge clk);
        #1 cd_model = 1'b0;
      end
    end
  end

  // Checker.
  initial begin
    logic [127:0] mk, mn;
    logic [39:0]  ma, mt;
    nvec = 0; nerr = 0; txn_seen = 0; pin_seen = 0; ncyc = 0;
    in_cnt = 0; oidx = 0; done_cnt = 0; started = 0; got_cd = 0; hold_v = 0; got = '0;
    last_in_at = -10; core_done_at = -10; last_out_at = -10; hold_dat = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (txn != txn_seen) begin
        txn_seen = txn; in_cnt = 0; oidx = 0; done_cnt = 0; started = 0; got_cd = 0;
        hold_v = 0; got = '0; last_in_at = -10; core_done_at = -10; last_out_at = -10;
      end
      if (pin_req != pin_seen) begin
        pin_seen = pin_req;
        case (pin_kind)
          1: begin
            chk("rst_ctrl", {busy, in_ready, out_valid, out_last, done, auth_fail, core_start,
                             core_mode}, 8'h00);
            chk("rst_out_data", out_data, 8'h00);
            chk("rst_key", core_key, 128'h0);
            chk("rst_nonce", core_nonce, 128'h0);
            chk("rst_ad_text", {core_ad, core_text_in}, 80'h0);
          end
          2: begin
            chk("enc_key", core_key, 128'h000102030405060708090a0b0c0d0e0f);
            chk("enc_nonce", core_nonce, 128'h101112131415161718191a1b1c1d1e1f);
            chk("enc_ad", core_ad, 40'h2021222324);
            chk("enc_text", core_text_in, 40'h2526272829);
            chk("enc_stream", got, {40'h0123456789, {16{8'hA5}}});
            chk("enc_beats", oidx, 21);
            chk("enc_auth", auth_fail, 1'b0);
          end
          3: begin
            chk("dec_plain", got[39:0], 40'h0123456789);
            chk("dec_beats", oidx, 5);
            chk("dec_auth", auth_fail, 1'b0);
          end
          4: begin
            chk("bad_auth_held", auth_fail, 1'b1);
            chk("bad_beats", oidx, 0);
            chk("bad_busy", busy, 1'b0);
          end
          5: begin
            chk("restart_auth_clr", auth_fail, 1'b0);
            chk("restart_busy", busy, 1'b1);
          end
          6: begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_in_ready", in_ready, 1'b0);
          end
          default: chk("timeouts", n_tmo, 0);
        endcase
      end
      if (rst) begin
        if (in_valid && in_ready) begin
          in_cnt++;
          if (in_cnt == exp_in) last_in_at = ncyc;
        end
        if (core_start) begin
          started = 1;
          mk = '0; mn = '0; ma = '0; mt = '0;
          for (int i = 0; i < 16; i++) mk = {mk[119:0], b[i]};
          for (int i = 16; i < 32; i++) mn = {mn[119:0], b[i]};
          for (int i = 32; i < 37; i++) ma = {ma[31:0], b[i]};
          for (int i = 37; i < 42; i++) mt = {mt[31:0], b[i]};
          chk("start_latency", ncyc, last_in_at + 1);
          chk("start_in_ready", in_ready, 1'b0);
          chk("core_key", core_key, mk);
          chk("core_nonce", core_nonce, mn);
          chk("core_ad", core_ad, ma);
          chk("core_text_in", core_text_in, mt);
          chk("core_mode", core_mode, exp_mode);
        end
        if (core_done && started && !got_cd) begin
          got_cd = 1;
          core_done_at = ncyc;
        end
        if (got_cd && exp_n > 0 && ncyc == core_done_at + 1)
          chk("first_out_latency", out_valid, 1'b1);
        if (out_valid) begin
          chk("out_in_range", oidx < exp_n, 1'b1);
          if (oidx < exp_n) begin
            chk("out_data", out_data, exp_bytes[oidx]);
            chk("out_last", out_last, oidx == exp_n - 1);
          end
          if (hold_v) chk("out_hold", {out_data, out_last}, hold_dat);
          if (out_ready) begin
            got = {got[159:0], out_data};
            oidx++;
            if (oidx == exp_n) last_out_at = ncyc;
            hold_v = 0;
          end else begin
            hold_v = 1;
            hold_dat = {out_data, out_last};
          end
        end else begin
          hold_v = 0;
        end
        if (done) begin
          chk("done_expected", exp_done && done_cnt == 0, 1'b1);
          chk("done_beats", oidx, exp_n);
          chk("done_auth", auth_fail, exp_auth);
          chk("done_latency", ncyc, (exp_n > 0 ? last_out_at : core_done_at) + 1);
          done_cnt++;
        end
      end
    end
  end

  // Stimulus.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input int k);
    pin_kind = k;
    pin_req++;
    @(negedge clk);
    tick();
  endtask

  task automatic setup(input logic m, input logic flip);
    logic [127:0] rx;
    rx = '0;
    for (int i = 0; i < 58; i++) b[i] = (i < 42) ? 8'(i) : 8'hA5;
    if (flip) b[57] = b[57] ^ 8'h01;
    for (int i = 42; i < 58; i++) rx = {rx[119:0], b[i]};
    exp_mode = m;
    exp_in   = m ? 58 : 42;
    exp_auth = m && (rx != core_tag);
    exp_n    = 0;
    if (!exp_auth) begin
      for (int i = 0; i < 5; i++) exp_bytes[i] = core_text_out[39-8*i -: 8];
      exp_n = 5;
      if (!m) begin
        for (int i = 0; i < 16; i++) exp_bytes[5+i] = core_tag[127-8*i -: 8];
        exp_n = 21;
      end
    end
    exp_done = 1'b1;
    txn++;
  endtask

  task automatic do_start(input logic m);
    start_in = 1'b1;
    mode_in  = m;
    tick();
    start_in = 1'b0;
  endtask

  task automatic feed(input int n, input logic gaps, input logic spur);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      in_data  = b[i];
      if (spur && i == 10) start_in = 1'b1;
      if (spur && i == 15) spur_cd = 1'b1;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) n_tmo++;
      tick();
      start_in = 1'b0;
      spur_cd  = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic stall, input logic spur);
    int   t;
    logic stalled, sent;
    stalled = 0; sent = 0;
    for (t = 0; t < 300; t++) begin
      tick();
      if (done_cnt > 0) break;
      if (stall && !stalled && oidx == 5) begin
        stalled = 1;
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
      if (spur && !sent && exp_n > 0 && oidx == exp_n) begin
        sent = 1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
      end
    end
    if (t >= 300) n_tmo++;
    repeat (2) tick();
  endtask

  task automatic reset_pulse();
    exp_done = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    pin(1);
  endtask

  initial begin
    int t;
    rst = 1'b0; start_in = 1'b0; mode_in = 1'b0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b1; spur_cd = 1'b0;
    txn = 0; pin_req = 0; pin_kind = 0; n_tmo = 0;
    exp_n = 0; exp_in = 42; exp_mode = 0; exp_auth = 0; exp_done = 0;
    for (int i = 0; i < 58; i++) b[i] = '0;
    for (int i = 0; i < 21; i++) exp_bytes[i] = '0;
    repeat (2) tick();
    rst = 1'b1;
    pin(1);

    // Plain encrypt.
    setup(1'b0, 1'b0); do_start(1'b0); feed(42, 1'b0, 1'b0); wait_done(1'b0, 1'b0);
    pin(2); pin(6);

    // Decrypt, tag matches.
    setup(1'b1, 1'b0); do_start(1'b1); feed(58, 1'b0, 1'b0); wait_done(1'b0, 1'b0);
    pin(3); pin(6);

    // Decrypt, tag mismatch; flag must persist through IDLE.
    setup(1'b1, 1'b1); do_start(1'b1); feed(58, 1'b0, 1'b0); wait_done(1'b0, 1'b0);
    repeat (3) tick();
    pin(4);

    // Next start clears the flag.
    setup(1'b1, 1'b0); do_start(1'b1); pin(5); feed(58, 1'b0, 1'b0); wait_done(1'b0, 1'b0);
    pin(3);

    // Input gaps and output stall.
    setup(1'b0, 1'b0); do_start(1'b0); feed(42, 1'b1, 1'b0); wait_done(1'b1, 1'b0);
    pin(2);

    // Reset during LOAD.
    setup(1'b0, 1'b0); do_start(1'b0); feed(20, 1'b0, 1'b0);
    reset_pulse();
    repeat (5) tick();

    // Reset during OUT after three beats.
    setup(1'b0, 1'b0); do_start(1'b0); feed(42, 1'b0, 1'b0);
    for (t = 0; t < 100 && oidx < 3; t++) tick();
    if (t >= 100) n_tmo++;
    reset_pulse();
    repeat (5) tick();

    // Clean encrypt after resets.
    setup(1'b0, 1'b0); do_start(1'b0); feed(42, 1'b0, 1'b0); wait_done(1'b0, 1'b0);
    pin(2);

    // Spurious events: in_valid in IDLE, start in LOAD/WAIT/DONE, core_done in LOAD.
    setup(1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (2) tick();
    pin(6);
    in_valid = 1'b0;
    do_start(1'b0); feed(42, 1'b0, 1'b1);
    tick();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_done(1'b0, 1'b1);
    pin(2); pin(6);

    pin(7);
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
